// File: rtl/dma_arbiter.sv
// Round-robin arbiter that shares one DMA engine among NREQ requesters, splitting each transfer
// into bursts that stay inside MAX_BURST-aligned windows; one burst in flight, waits on dma_interrupt_i.
module dma_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ-1:0]           req_read_i,
  input  logic [NREQ*32-1:0]        req_addr_i,
  input  logic [NREQ*32-1:0]        req_len_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [NREQ-1:0]           req_done_o,
  output logic                      busy_o,
  output logic [$clog2(NREQ)-1:0]   grant_id_o,
  output logic                      dma_enable_o,
  output logic                      dma_read_o,
  output logic [31:0]               dma_addr_o,
  output logic [31:0]               dma_len_o,
  input  logic                      dma_interrupt_i
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [31:0] MB      = 32'(MAX_BURST);
  localparam logic [31:0] MB_MASK = MB - 32'd1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

  state_t          state, next_state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  win;
  logic            win_vld;
  logic            accept;
  logic [31:0]     win_addr, win_len;
  logic [31:0]     cur_addr, rem, chunk;
  logic            cur_read;
  logic [31:0]     span, chunk_calc;

  // Rotating priority: search begins just after the previous winner.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win     = '0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant) + i) % NREQ;
      if (!win_vld && req_valid_i[idx]) begin
        win_vld = 1'b1;
        win     = idx[IDW-1:0];
      end
    end
  end

  assign accept      = (state == IDLE) && win_vld;
  assign win_addr    = req_addr_i[32*win +: 32];
  assign win_len     = req_len_i[32*win +: 32];
  assign req_ready_o = (accept && !rst) ? (ONE << win) : '0;
  assign req_done_o  = (state == DONE) ? (ONE << grant_id_o) : '0;
  assign busy_o      = (state != IDLE);

  // Bytes left before the next MAX_BURST-aligned boundary.
  assign span       = MB - (cur_addr & MB_MASK);
  assign chunk_calc = (rem < span) ? rem : span;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (win_len == 32'd0) ? DONE : CALC;
      CALC:    next_state = ISSUE;
      ISSUE:   if (dma_interrupt_i) next_state = (rem == chunk) ? DONE : CALC;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      grant_id_o   <= '0;
      cur_addr     <= '0;
      rem          <= '0;
      chunk        <= '0;
      cur_read     <= 1'b0;
      dma_enable_o <= 1'b0;
      dma_read_o   <= 1'b0;
      dma_addr_o   <= '0;
      dma_len_o    <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        last_grant <= win;
        grant_id_o <= win;
        cur_addr   <= win_addr;
        rem        <= win_len;
        cur_read   <= req_read_i[win];
      end
      if (state == CALC) begin
        chunk        <= chunk_calc;
        dma_enable_o <= 1'b1;
        dma_addr_o   <= cur_addr;
        dma_len_o    <= chunk_calc;
        dma_read_o   <= cur_read;
      end
      if (state == ISSUE && dma_interrupt_i) begin
        cur_addr     <= cur_addr + chunk;
        rem          <= rem - chunk;
        dma_enable_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboarded bench for dma_arbiter: directed transfers push expected bursts/done pulses,
// an independent monitor pops and compares them as the DUT presents them.
module tb_dma_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid_i, req_read_i;
  logic [127:0] req_addr_i, req_len_i;
  logic [3:0]   req_ready_o, req_done_o;
  logic         busy_o;
  logic [1:0]   grant_id_o;
  logic         dma_enable_o, dma_read_o;
  logic [31:0]  dma_addr_o, dma_len_o;
  logic         dma_interrupt_i;
  logic         irq_man, irq_auto, auto_irq;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] l;
    logic        r;
  } burst_t;

  burst_t     qb[$];
  logic [3:0] qd[$];
  int         checks = 0;
  int         errors = 0;
  logic       prev_en = 1'b0;

  assign dma_interrupt_i = irq_man | irq_auto;

  dma_arbiter #(.NREQ(4), .MAX_BURST(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_read_i(req_read_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_ready_o(req_ready_o), .req_done_o(req_done_o),
    .busy_o(busy_o), .grant_id_o(grant_id_o),
    .dma_enable_o(dma_enable_o), .dma_read_o(dma_read_o),
    .dma_addr_o(dma_addr_o), .dma_len_o(dma_len_o),
    .dma_interrupt_i(dma_interrupt_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    errors++;
    $display("FAIL %s: wait bound expired at %0t (%0d checks, %0d errors)", name, $time, checks, errors);
    $fatal(1, "bench aborted");
  endtask

  task automatic set_req(input int id, input logic rd, input logic [31:0] addr, input logic [31:0] len);
    req_read_i[id]        = rd;
    req_addr_i[32*id +: 32] = addr;
    req_len_i[32*id +: 32]  = len;
  endtask

  task automatic exp_b(input logic [31:0] addr, input logic [31:0] len, input logic rd);
    burst_t b;
    b.a = addr; b.l = len; b.r = rd;
    qb.push_back(b);
  endtask

  // Monitor: compares every burst start and every done pulse against the scoreboard.
  initial begin
    burst_t     b;
    logic [3:0] d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dma_enable_o && !prev_en) begin
          if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL burst_unexpected: got addr 0x%08h len 0x%08h, expected no burst", dma_addr_o, dma_len_o);
          end else begin
            b = qb.pop_front();
            chk("burst_addr", dma_addr_o, b.a);
            chk("burst_len", dma_len_o, b.l);
            chk("burst_read", 32'(dma_read_o), 32'(b.r));
          end
        end
        if (req_done_o != 4'b0) begin
          if (qd.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got 0x%0h, expected no done", req_done_o);
          end else begin
            d = qd.pop_front();
            chk("done_mask", 32'(req_done_o), 32'(d));
          end
        end
      end
      prev_en = dma_enable_o & ~rst;
    end
  end

  // Automatic interrupt responder used for the round-robin sequences.
  initial begin
    irq_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_irq && dma_enable_o && !rst) begin
        irq_auto = 1'b1;
        @(negedge clk);
        irq_auto = 1'b0;
      end
    end
  end

  task automatic rr_one(input int id, input logic [31:0] addr, input logic rd);
    logic [3:0] m;
    int n;
    m = 4'b0001 << id;
    exp_b(addr, 32'd4, rd);
    qd.push_back(m);
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready_o == 4'b0 && n < 50);
    if (req_ready_o == 4'b0) timeout("rr_ready_wait");
    chk("rr_grant", 32'(req_ready_o), 32'(m));
    @(posedge clk); #1;
    req_valid_i = req_valid_i & ~m;
    chk("rr_grant_id", 32'(grant_id_o), 32'(id));
    n = 0;
    do begin @(negedge clk); n++; end while (req_done_o == 4'b0 && n < 50);
    if (req_done_o == 4'b0) timeout("rr_done_wait");
  endtask

  task automatic run_req(input int id, input logic rd, input logic [31:0] addr, input logic [31:0] len,
                         input int nb, input bit stray, input logic [3:0] other);
    logic [3:0] m;
    int n;
    m = 4'b0001 << id;
    @(posedge clk); #1;
    set_req(id, rd, addr, len);
    req_valid_i = req_valid_i | m | other;
    qd.push_back(m);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready_o[id] && n < 50);
    if (!req_ready_o[id]) timeout("ready_wait");
    chk("ready_onehot", 32'(req_ready_o), 32'(m));
    #1 req_valid_i = req_valid_i & ~other;
    @(posedge clk); #1;
    req_valid_i = req_valid_i & ~m;
    chk("grant_id", 32'(grant_id_o), 32'(id));
    @(negedge clk);
    chk("busy_T1", 32'(busy_o), 32'd1);
    chk("en_T1", 32'(dma_enable_o), 32'd0);
    if (stray) irq_man = 1'b1;
    if (nb == 0) begin
      chk("zero_done_T1", 32'(req_done_o), 32'(m));
      @(negedge clk);
      chk("zero_en_T2", 32'(dma_enable_o), 32'd0);
      chk("zero_idle_T2", 32'(busy_o), 32'd0);
    end else begin
      for (int b = 0; b < nb; b++) begin
        @(negedge clk);
        irq_man = 1'b0;
        chk("en_rise", 32'(dma_enable_o), 32'd1);
        repeat (b + int'(stray)) begin
          @(negedge clk);
          chk("en_hold", 32'(dma_enable_o), 32'd1);
        end
        irq_man = 1'b1;
        @(negedge clk);
        irq_man = 1'b0;
        chk("en_fall", 32'(dma_enable_o), 32'd0);
        if (b == nb - 1) chk("done_I1", 32'(req_done_o), 32'(m));
        else             chk("calc_busy", 32'(busy_o), 32'd1);
      end
      @(negedge clk);
      chk("idle_I2", 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (%0d checks, %0d errors)", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    irq_man = 1'b0;
    auto_irq = 1'b0;
    req_valid_i = 4'b0;
    req_read_i = 4'b0;
    req_addr_i = '0;
    req_len_i = '0;
    for (int i = 0; i < 4; i++) set_req(i, i[0], 32'(256 * (i + 1)), 32'd4);
    req_valid_i = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_done", 32'(req_done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_grant", 32'(grant_id_o), 32'd0);
    chk("rst_en", 32'(dma_enable_o), 32'd0);
    chk("rst_addr", dma_addr_o, 32'd0);
    chk("rst_len", dma_len_o, 32'd0);
    chk("rst_read", 32'(dma_read_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All four valid from reset: 0,1,2,3
    auto_irq = 1'b1;
    rr_one(0, 32'h100, 1'b0);
    rr_one(1, 32'h200, 1'b1);
    rr_one(2, 32'h300, 1'b0);
    rr_one(3, 32'h400, 1'b1);
    // req0 and req2 re-request after last_grant = 3: 0 then 2
    @(posedge clk); #1;
    req_valid_i = 4'b0101;
    rr_one(0, 32'h100, 1'b0);
    rr_one(2, 32'h300, 1'b0);
    auto_irq = 1'b0;

    // Aligned split
    exp_b(32'h1000, 32'd256, 1'b1);
    exp_b(32'h1100, 32'd256, 1'b1);
    exp_b(32'h1200, 32'd256, 1'b1);
    run_req(1, 1'b1, 32'h1000, 32'h300, 3, 1'b0, 4'b0);

    // last_grant = 1, req3 and req1 pending: 3 first
    auto_irq = 1'b1;
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h200, 32'd4);
    set_req(3, 1'b1, 32'h400, 32'd4);
    req_valid_i = 4'b1010;
    rr_one(3, 32'h400, 1'b1);
    rr_one(1, 32'h200, 1'b1);
    auto_irq = 1'b0;

    // Stray interrupt in IDLE
    @(posedge clk); #1;
    irq_man = 1'b1;
    @(posedge clk); #1;
    irq_man = 1'b0;
    chk("stray_idle_busy", 32'(busy_o), 32'd0);
    chk("stray_idle_en", 32'(dma_enable_o), 32'd0);
    chk("stray_idle_done", 32'(req_done_o), 32'd0);

    // Unaligned start, write direction, stray interrupt during CALC
    exp_b(32'h10F0, 32'd16, 1'b0);
    exp_b(32'h1100, 32'd48, 1'b0);
    run_req(3, 1'b0, 32'h10F0, 32'h40, 2, 1'b1, 4'b0);

    // Zero length
    run_req(2, 1'b0, 32'h5000, 32'h0, 0, 1'b0, 4'b0);

    // Reset during ISSUE of a 0x300-byte transfer
    exp_b(32'h3000, 32'd256, 1'b1);
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h3000, 32'h300);
    req_valid_i = 4'b0010;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready_o[1] && n < 50);
    if (!req_ready_o[1]) timeout("rst_test_ready_wait");
    @(posedge clk); #1;
    req_valid_i = 4'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_test_en", 32'(dma_enable_o), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_en", 32'(dma_enable_o), 32'd0);
    chk("midrst_addr", dma_addr_o, 32'd0);
    chk("midrst_len", dma_len_o, 32'd0);
    chk("midrst_read", 32'(dma_read_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_grant", 32'(grant_id_o), 32'd0);
    chk("midrst_done", 32'(req_done_o), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    irq_man = 1'b1;
    @(negedge clk);
    irq_man = 1'b0;
    chk("late_irq_busy", 32'(busy_o), 32'd0);
    chk("late_irq_done", 32'(req_done_o), 32'd0);
    @(negedge clk);
    chk("late_irq_done2", 32'(req_done_o), 32'd0);
    chk("late_irq_en", 32'(dma_enable_o), 32'd0);
    // req0 wins over req3 because last_grant is back at 3
    exp_b(32'h7080, 32'd32, 1'b0);
    set_req(3, 1'b0, 32'h9000, 32'd4);
    run_req(0, 1'b0, 32'h7080, 32'h20, 1, 1'b0, 4'b1000);

    repeat (5) @(negedge clk);
    chk("burst_queue_empty", 32'(qb.size()), 32'd0);
    chk("done_queue_empty", 32'(qd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Shares the single DMA engine between the four tile-level transfer requesters (filter, ifmap, bias, opsum write-back) driven by the tile scheduler. It arbitrates round-robin, splits each request into bursts that never cross a MAX_BURST-aligned address boundary, and drives the DMA command port. It waits for one `dma_interrupt_i` per burst, then signals per-requester completion. The block sits between the tile scheduler's transfer requests and the DMA engine.

## Interface

Parameters:
- NREQ, 4, number of requesters; index 0 = filter, 1 = ifmap, 2 = bias, 3 = opsum.
- MAX_BURST, 256, maximum bytes per DMA command; power of two, at least 4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid_i  in  NREQ  per-requester transfer request; held with its payload until accepted.
- req_read_i  in  NREQ  per-requester direction; 1 = DRAM→GLB, 0 = GLB→DRAM.
- req_addr_i  in  NREQ×32  per-requester DRAM byte address, packed with requester i at bits [32i+31:32i].
- req_len_i  in  NREQ×32  per-requester byte length, packed the same way.
- req_ready_o  out  NREQ  one-hot acceptance pulse.
- req_done_o  out  NREQ  one-hot single-cycle completion pulse.
- busy_o  out  1  high whenever the state is not IDLE.
- grant_id_o  out  $clog2(NREQ)  index of the current or most recent grant.
- dma_enable_o  out  1  DMA command valid.
- dma_read_o  out  1  burst direction.
- dma_addr_o  out  32  burst byte address.
- dma_len_o  out  32  burst byte length.
- dma_interrupt_i  in  1  single-cycle pulse marking completion of the current burst.

## Operation

- States:
  - IDLE → CALC: taken on acceptance of a request with nonzero length.
  - IDLE → DONE: taken on acceptance of a request with zero length.
  - CALC → ISSUE: unconditional.
  - ISSUE → CALC: taken on `dma_interrupt_i` when `rem` is still nonzero after the update.
  - ISSUE → DONE: taken on `dma_interrupt_i` when `rem` becomes zero.
  - DONE → IDLE: unconditional.
- Arbitration (IDLE only):
  - Search starts at (`last_grant` + 1) mod NREQ and wraps; the first index with `req_valid_i` set wins.
  - `last_grant` resets to NREQ−1, so requester 0 has first priority after reset.
  - `last_grant` updates to the winner on acceptance.
- Acceptance:
  - `req_ready_o[g]` is high combinationally in IDLE for the winner g only.
  - The handshake completes when `req_valid_i[g] & req_ready_o[g]`.
  - On that cycle the block latches `cur_addr`, `rem`, `cur_read` and `grant_id`.
  - After acceptance the requester may drop or change its inputs.
- Burst split (CALC registers `chunk`):
  - `chunk = min(rem, MAX_BURST − (cur_addr & (MAX_BURST−1)))`, computed in 32-bit unsigned arithmetic.
  - A burst therefore never crosses a MAX_BURST-aligned boundary.
- ISSUE:
  - `dma_enable_o` = 1, `dma_addr_o` = `cur_addr`, `dma_len_o` = `chunk`, `dma_read_o` = `cur_read`.
  - All four outputs are registered and held stable until `dma_interrupt_i`.
  - On the interrupt: `cur_addr += chunk`, `rem −= chunk`, and `dma_enable_o` deasserts on the next cycle.
- DONE: `req_done_o[grant_id]` = 1 for exactly one cycle.
- `dma_interrupt_i` outside ISSUE is ignored and has no effect on any state.
- Requests from other requesters stay pending while a transfer is in flight. The block never pre-empts a transfer in progress.
- Address wrap past 0xFFFFFFFF is modulo 2^32. The block does no error checking.

## Timing

- Reset values: all outputs 0, state IDLE, `last_grant` = NREQ−1, `cur_addr`/`rem`/`chunk` = 0.
- Reset asserted mid-transfer:
  - All outputs clear immediately (asynchronously).
  - The in-flight transfer is dropped and no `req_done_o` is issued for it.
  - A late `dma_interrupt_i` after reset is ignored.
- Cycle latencies:
  - Acceptance occurs at cycle T.
  - CALC is at T+1.
  - `dma_enable_o` first rises at T+2.
  - After each interrupt at cycle I, the next burst asserts `dma_enable_o` at I+2 (one CALC cycle between bursts).
- Completion:
  - `req_done_o` fires at I+1 after the final interrupt.
  - The next acceptance is possible at I+2.
  - A zero-length request is done at T+1 and never asserts `dma_enable_o`.
- An interrupt arriving in the same cycle that `dma_enable_o` first rises is valid and completes the burst.

## Test plan

- **Aligned split:** req1 read, addr 0x1000, len 0x300 → bursts (0x1000,256), (0x1100,256), (0x1200,256), all with `dma_read_o` = 1. `req_done_o` = 0b0010 one cycle after the third interrupt.
- **Unaligned start and write direction:** req3 write, addr 0x10F0, len 0x40 → bursts (0x10F0,16), (0x1100,48) with `dma_read_o` = 0, then done on bit 3.
- **Round-robin:**
  - All four requesters valid from reset → grant order 0, 1, 2, 3.
  - Then req0 and req2 re-request → grant order 0, 2.
  - With req3 and req1 valid while `last_grant` = 1 → req3 is granted first.
- **Zero length:** req2 len 0 → ready at T, done at T+1, `dma_enable_o` stays 0 throughout.
- **Stray interrupt:** `dma_interrupt_i` pulsed in IDLE and in CALC → no state, address or done change. The transfer completes only on interrupts received in ISSUE.
- **Reset mid-transfer:** `rst` pulsed during ISSUE of a 0x300-byte transfer → all outputs 0 and no done pulse. A new req0 request afterwards is granted first and runs from its own address.
